level_sequencer: RTL
====================

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50000000: Clk cycles per game second.
REQ-002 Parameter NUM_LEVELS, default 2: number of playable levels, minimum 1.
REQ-003 Parameter MAX_OBJ, default 10: objects spawned per level, minimum 1.
REQ-004 Parameter SPAWN_SEC, default 2: seconds between successive object spawns, minimum 1.
REQ-005 Parameter INTRO_SEC, default 1: seconds the level intro card is shown.
REQ-006 Parameter BLINK_TICKS, default 25000000: Clk cycles per title-prompt toggle.
REQ-007 Parameter LIVES, default 3: starting lives, used only with LVLSEQ_LIVES_EN.
REQ-008 Clk  input  1  system clock; reset Reset, asynchronous, active-high; clock Clk.
REQ-009 Reset  input  1  asynchronous active-high reset.
REQ-010 Run  input  1  start/continue pushbutton, level-sensitive.
REQ-011 keycode  input  8  keyboard scan code; value 40 (Enter) is equivalent to Run.
REQ-012 collision  input  1  player hit, synchronous to Clk.
REQ-013 level_clear  input  1  last object has left the screen, synchronous.
REQ-014 obj_ready  output  MAX_OBJ  thermometer of active objects; bit i enables object i.
REQ-015 level  output  $clog2(NUM_LEVELS+1)  current level index, 0-based.
REQ-016 title, prompt, intro, win  output  1 each  screen selects: title, blinking prompt, intro card, win screen.
REQ-017 seconds  output  10  seconds elapsed in current state.
REQ-018 lives  output  3  remaining lives; constant LIVES when the feature is compiled out.

Function
REQ-019 States SHALL be TITLE, INTRO, SPAWN, HOLD, WIN; all outputs SHALL be Moore-decoded from registered state and counters.
REQ-020 Tick counter SHALL count 0..TICKS_PER_SEC-1 in INTRO, SPAWN and HOLD; on its wrap, seconds SHALL increment by 1, saturating at 1023.
REQ-021 Every state transition SHALL clear the tick counter and seconds in the same edge.
REQ-022 TITLE: title=1; prompt SHALL toggle every BLINK_TICKS cycles; Run or keycode==40 -> INTRO with level=0.
REQ-023 INTRO: intro=1; when seconds==INTRO_SEC -> SPAWN with object count=1.
REQ-024 SPAWN: obj_ready low count bits =1; when seconds==SPAWN_SEC, count SHALL increment and seconds clear; the increment that reaches MAX_OBJ SHALL go to HOLD.
REQ-025 HOLD: all obj_ready bits =1; level_clear -> INTRO with level+1 if level<NUM_LEVELS-1, else -> WIN.
REQ-026 level_clear SHALL be ignored outside HOLD; collision SHALL be ignored outside SPAWN and HOLD.
REQ-027 Collision in SPAWN or HOLD SHALL restart the current level at SPAWN with count=1, seconds=0, same level.
REQ-028 Collision SHALL take priority over level_clear and over a spawn increment in the same cycle.
REQ-029 WIN: win=1, obj_ready=0; Run or keycode==40 -> TITLE.
REQ-030 obj_ready SHALL be all zero in TITLE, INTRO and WIN; intro, title and win SHALL be mutually exclusive.

Reset
REQ-031 Reset SHALL force, asynchronously, state=TITLE, level=0, count=0, seconds=0, tick and blink counters=0, prompt=0, lives=LIVES.
REQ-032 Assertion of Reset in any state, including mid-spawn, SHALL discard all progress; first edge after release evaluates TITLE.

Configuration
REQ-033 Macro LVLSEQ_LIVES_EN defined: each accepted collision SHALL decrement lives; a collision with lives==1 SHALL go to TITLE with lives reloaded to LIVES instead of restarting the level.
REQ-034 LVLSEQ_LIVES_EN undefined: unlimited retries per REQ-027; lives output tied to LIVES.

Verification (TICKS_PER_SEC=4, MAX_OBJ=3, SPAWN_SEC=2, INTRO_SEC=1, NUM_LEVELS=2, BLINK_TICKS=3, LIVES=2)
REQ-035 Reset, keycode=40 for 1 cycle -> intro=1 next cycle; SPAWN with obj_ready=001 after 4 cycles; 011 after 8 more; HOLD obj_ready=111 after 8 more.
REQ-036 In TITLE with no input -> prompt toggles every 3 cycles; keycode=39 -> no state change.
REQ-037 collision in HOLD level 1 -> obj_ready=001, seconds=0, level=1; collision and level_clear same cycle -> restart, no level advance.
REQ-038 level_clear in HOLD level 0 -> INTRO level=1; level_clear in HOLD level 1 -> win=1; Run -> title=1.
REQ-039 With LVLSEQ_LIVES_EN: two collisions -> lives 2->1 then TITLE with lives=2; without: lives stays 2, level restarts each time.
REQ-040 Reset asserted mid-SPAWN between edges -> title=1, obj_ready=000, level=0 immediately, without waiting for Clk.

Source files
------------

// File: rtl/level_sequencer.sv
// Game level sequencer: title -> intro -> timed object spawn -> hold -> win; outputs decode registered state.
// Latency: one Clk per transition; no backpressure. Optional lives counter under `LVLSEQ_LIVES_EN`.
module level_sequencer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int NUM_LEVELS    = 2,
    parameter int MAX_OBJ       = 10,
    parameter int SPAWN_SEC     = 2,
    parameter int INTRO_SEC     = 1,
    parameter int BLINK_TICKS   = 25000000,
    parameter int LIVES         = 3,
    localparam int LW = $clog2(NUM_LEVELS + 1),
    localparam int CW = $clog2(MAX_OBJ + 1),
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1,
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic [7:0]         keycode,
    input  logic               collision,
    input  logic               level_clear,
    output logic [MAX_OBJ-1:0] obj_ready,
    output logic [LW-1:0]      level,
    output logic               title,
    output logic               prompt,
    output logic               intro,
    output logic               win,
    output logic [9:0]         seconds,
    output logic [2:0]         lives
);

    typedef enum logic [2:0] {S_TITLE, S_INTRO, S_SPAWN, S_HOLD, S_WIN} state_t;

    state_t        state_q;
    logic [LW-1:0] level_q;
    logic [CW-1:0] count_q;
    logic [9:0]    sec_q;
    logic [TW-1:0] tick_q;
    logic [BW-1:0] blink_q;
    logic          prompt_q;
`ifdef LVLSEQ_LIVES_EN
    logic [2:0]    lives_q;
`endif

    logic          start;
    logic          timed;
    logic          tick_wrap;
    logic          blink_wrap;
    logic          hit;
    logic [9:0]    sec_inc;
    logic [CW-1:0] count_inc;
    // With a single object the first spawn already completes the wave.
    state_t        spawn_entry;

    assign start       = Run | (keycode == 8'd40);
    assign timed       = (state_q == S_INTRO) || (state_q == S_SPAWN) || (state_q == S_HOLD);
    assign tick_wrap   = (tick_q == TW'(TICKS_PER_SEC - 1));
    assign blink_wrap  = (blink_q == BW'(BLINK_TICKS - 1));
    assign hit         = collision && ((state_q == S_SPAWN) || (state_q == S_HOLD));
    assign sec_inc     = (sec_q == 10'd1023) ? sec_q : sec_q + 10'd1;
    assign count_inc   = count_q + CW'(1);
    assign spawn_entry = (MAX_OBJ == 1) ? S_HOLD : S_SPAWN;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_TITLE;
            level_q  <= '0;
            count_q  <= '0;
            sec_q    <= '0;
            tick_q   <= '0;
            blink_q  <= '0;
            prompt_q <= 1'b0;
`ifdef LVLSEQ_LIVES_EN
            lives_q  <= 3'(LIVES);
`endif
        end else begin
            // Free-running time base; any transition below overrides with a clear.
            if (timed) begin
                tick_q <= tick_wrap ? '0 : tick_q + TW'(1);
                if (tick_wrap) sec_q <= sec_inc;
            end
            if (state_q == S_TITLE) begin
                blink_q <= blink_wrap ? '0 : blink_q + BW'(1);
                if (blink_wrap) prompt_q <= ~prompt_q;
            end else begin
                blink_q  <= '0;
                prompt_q <= 1'b0;
            end

            if (hit) begin
                tick_q <= '0;
                sec_q  <= '0;
`ifdef LVLSEQ_LIVES_EN
                if (lives_q == 3'd1) begin
                    state_q <= S_TITLE;
                    level_q <= '0;
                    count_q <= '0;
                    lives_q <= 3'(LIVES);
                end else begin
                    state_q <= spawn_entry;
                    count_q <= CW'(1);
                    lives_q <= lives_q - 3'd1;
                end
`else
                state_q <= spawn_entry;
                count_q <= CW'(1);
`endif
            end else begin
                case (state_q)
                    S_TITLE: if (start) begin
                        state_q <= S_INTRO;
                        level_q <= '0;
                        count_q <= '0;
                        tick_q  <= '0;
                        sec_q   <= '0;
`ifdef LVLSEQ_LIVES_EN
                        lives_q <= 3'(LIVES);
`endif
                    end
                    S_INTRO: if (tick_wrap && (sec_inc == 10'(INTRO_SEC))) begin
                        state_q <= spawn_entry;
                        count_q <= CW'(1);
                        tick_q  <= '0;
                        sec_q   <= '0;
                    end
                    S_SPAWN: if (tick_wrap && (sec_inc == 10'(SPAWN_SEC))) begin
                        count_q <= count_inc;
                        tick_q  <= '0;
                        sec_q   <= '0;
                        if (count_inc == CW'(MAX_OBJ)) state_q <= S_HOLD;
                    end
                    S_HOLD: if (level_clear) begin
                        count_q <= '0;
                        tick_q  <= '0;
                        sec_q   <= '0;
                        if (level_q < LW'(NUM_LEVELS - 1)) begin
                            state_q <= S_INTRO;
                            level_q <= level_q + LW'(1);
                        end else begin
                            state_q <= S_WIN;
                        end
                    end
                    S_WIN: if (start) begin
                        state_q <= S_TITLE;
                        level_q <= '0;
                        count_q <= '0;
                        tick_q  <= '0;
                        sec_q   <= '0;
                    end
                    default: state_q <= S_TITLE;
                endcase
            end
        end
    end

    always_comb begin
        obj_ready = '0;
        if (state_q == S_SPAWN) obj_ready = ~({MAX_OBJ{1'b1}} << count_q);
        else if (state_q == S_HOLD) obj_ready = {MAX_OBJ{1'b1}};
    end

    assign level   = level_q;
    assign title   = (state_q == S_TITLE);
    assign intro   = (state_q == S_INTRO);
    assign win     = (state_q == S_WIN);
    assign prompt  = prompt_q;
    assign seconds = sec_q;
`ifdef LVLSEQ_LIVES_EN
    assign lives   = lives_q;
`else
    assign lives   = 3'(LIVES);
`endif

endmodule
